// File: rtl/mem_access_unit.sv
// Load/store unit between the core's memory stage and a word-wide data memory
// with asynchronous read and synchronous write. Sub-word stores use a
// two-cycle read-modify-write; misaligned or illegal-size requests are rejected.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_misaligned,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic                    illegal;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   byte_shift;
    logic [DATA_WIDTH-1:0]   half_shift;
    logic [DATA_WIDTH-1:0]   merged;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic [15:0]             wdata_q;
    logic [DATA_WIDTH-1:0]   old_q;

    // Alignment/size legality of the request presented this cycle
    always_comb begin
        illegal = 1'b0;
        unique case (i_size)
            SIZE_BYTE: illegal = 1'b0;
            SIZE_HALF: illegal = i_addr[0];
            SIZE_WORD: illegal = |i_addr[1:0];
            default:   illegal = 1'b1;
        endcase
    end

    // Lane selection and sign/zero extension of the async read word
    always_comb begin
        byte_shift = i_mem_rdata >> {i_addr[1:0], 3'b000};
        half_shift = i_mem_rdata >> {i_addr[1], 4'b0000};
        load_data  = i_mem_rdata;
        unique case (i_size)
            SIZE_BYTE: load_data = i_unsigned ? {24'h0, byte_shift[7:0]}
                                              : {{24{byte_shift[7]}}, byte_shift[7:0]};
            SIZE_HALF: load_data = i_unsigned ? {16'h0, half_shift[15:0]}
                                              : {{16{half_shift[15]}}, half_shift[15:0]};
            default:   load_data = i_mem_rdata;
        endcase
    end

    // Merge the captured store bytes into the old word for the RMW write
    always_comb begin
        merged = old_q;
        if (size_q == SIZE_BYTE) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // FSM state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory-side outputs
    always_comb begin
        state_next  = state;
        o_ready     = 1'b0;
        accept      = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
        o_mem_wdata = i_wdata;
        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                accept  = i_req;
                if (accept && !illegal && i_we) begin
                    if (i_size == SIZE_WORD) begin
                        o_mem_we = 1'b1;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                o_mem_we    = 1'b1;
                o_mem_wdata = merged;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (i_reset) begin
            o_mem_we   = 1'b0;
            state_next = IDLE;
        end
    end

    // Completion/reject pulses, load data and RMW capture registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_rdata      <= '0;
            addr_q       <= '0;
            size_q       <= SIZE_BYTE;
            wdata_q      <= '0;
            old_q        <= '0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            if (accept) begin
                if (illegal) begin
                    o_misaligned <= 1'b1;
                end else if (!i_we) begin
                    o_rdata <= load_data;
                    o_done  <= 1'b1;
                end else if (i_size == SIZE_WORD) begin
                    o_done <= 1'b1;
                end else begin
                    addr_q  <= i_addr;
                    size_q  <= i_size;
                    wdata_q <= i_wdata[15:0];
                    old_q   <= i_mem_rdata;
                end
            end
            if (state == WRITE) begin
                o_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory and transaction model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clock(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_size(size), .i_unsigned(uns), .i_wdata(wdata), .o_ready(ready),
        .o_done(done), .o_rdata(rdata), .o_misaligned(mis), .o_mem_addr(mem_addr),
        .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Data memory: 64 words aliased over the address space, preload port for setup
    logic [31:0] dmem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;
    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pl_en) dmem[pl_idx] <= pl_data;
        else if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
    end

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wdata;
        bit          lit_on;
        logic [31:0] lit;
        bit          rst_in_write;
    } rq_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_b [256];
    bit          m_busy = 1'b0;
    rq_t         pend;
    bit          exp_ready = 1'b1;
    bit          exp_done = 1'b0;
    bit          exp_mis = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    bit          exp_lit_on = 1'b0;
    logic [31:0] exp_lit = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b0;
        return (a % nbytes(s)) == 0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a[7:0]) & 32'hFC;
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input bit u);
        int n;
        int b;
        logic [31:0] v;
        n = nbytes(s);
        b = int'(a[7:0]) & ~(n - 1);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_b[b+k]) << (8 * k));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int n;
        int b;
        n = nbytes(s);
        b = int'(a[7:0]) & ~(n - 1);
        for (int k = 0; k < n; k++) ref_b[b+k] = 8'(d >> (8 * k));
    endtask

    // One clock cycle: check registered outputs, drive inputs, check memory side, advance model
    task automatic step(input rq_t r, input logic rst_in);
        bit          e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        bit          n_ready, n_done, n_mis, n_busy, n_lit_on;
        logic [31:0] n_rdata, n_lit;

        chk("ready", 32'(ready), 32'(exp_ready));
        chk("done", 32'(done), 32'(exp_done));
        chk("misaligned", 32'(mis), 32'(exp_mis));
        chk("rdata", rdata, exp_rdata);
        if (exp_lit_on) chk("rdata_literal", rdata, exp_lit);

        rst   = rst_in;
        req   = r.req;
        we    = r.we;
        addr  = r.addr;
        size  = r.size;
        uns   = r.uns;
        wdata = r.wdata;
        #1;

        e_we     = 1'b0;
        e_addr   = {addr[31:2], 2'b00};
        e_wdata  = 32'd0;
        n_ready  = 1'b1;
        n_done   = 1'b0;
        n_mis    = 1'b0;
        n_busy   = 1'b0;
        n_rdata  = exp_rdata;
        n_lit_on = 1'b0;
        n_lit    = 32'd0;
        if (m_busy) e_addr = {pend.addr[31:2], 2'b00};

        if (rst_in) begin
            n_rdata = 32'd0;
        end else if (m_busy) begin
            ref_store(pend.addr, pend.size, pend.wdata);
            e_we    = 1'b1;
            e_wdata = ref_word(pend.addr);
            n_done  = 1'b1;
            if (pend.lit_on) chk("rmw_wdata_literal", mem_wdata, pend.lit);
        end else if (r.req) begin
            if (!legal(r.addr, r.size)) begin
                n_mis = 1'b1;
            end else if (!r.we) begin
                n_rdata  = ref_load(r.addr, r.size, r.uns);
                n_done   = 1'b1;
                n_lit_on = r.lit_on;
                n_lit    = r.lit;
            end else if (r.size == 2'b10) begin
                ref_store(r.addr, r.size, r.wdata);
                e_we    = 1'b1;
                e_wdata = r.wdata;
                n_done  = 1'b1;
            end else begin
                n_busy  = 1'b1;
                n_ready = 1'b0;
                pend    = r;
            end
        end

        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);

        m_busy     = n_busy;
        exp_ready  = n_ready;
        exp_done   = n_done;
        exp_mis    = n_mis;
        exp_rdata  = n_rdata;
        exp_lit_on = n_lit_on;
        exp_lit    = n_lit;
        @(negedge clk);
    endtask

    function automatic rq_t mk(input bit w, input logic [31:0] a, input logic [1:0] s,
                               input bit u, input logic [31:0] d, input bit lo,
                               input logic [31:0] l, input bit rw);
        rq_t r;
        r.req = 1'b1; r.we = w; r.addr = a; r.size = s; r.uns = u; r.wdata = d;
        r.lit_on = lo; r.lit = l; r.rst_in_write = rw;
        return r;
    endfunction

    function automatic rq_t rand_req();
        rq_t r;
        int  n;
        r = mk($urandom_range(0, 1) == 1, $urandom, 2'($urandom_range(0, 2)),
               $urandom_range(0, 1) == 1, $urandom, 1'b0, 32'd0, 1'b0);
        if ($urandom_range(0, 9) == 0) r.size = 2'b11;
        n = nbytes(r.size);
        if (r.size != 2'b11 && $urandom_range(0, 3) != 0) r.addr = r.addr & ~32'(n - 1);
        r.req = $urandom_range(0, 9) < 7;
        return r;
    endfunction

    rq_t q[$];
    rq_t idle_r;
    rq_t cur;
    bit  hold_rst;

    initial begin
        idle_r = mk(1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle_r.req = 1'b0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; size = 2'b00;
        uns = 1'b0; wdata = 32'd0;
        @(negedge clk);

        // Preload memory and reference under reset
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = (i == 4) ? 32'h8899_AABB : $urandom;
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = 8'(w >> (8 * k));
            pl_en = 1'b1; pl_idx = 6'(i); pl_data = w;
            step(idle_r, 1'b1);
        end
        pl_en = 1'b0;
        step(idle_r, 1'b0);

        q.push_back(mk(1'b0, 32'h11, 2'b00, 1'b1, 32'd0, 1'b1, 32'h0000_00AA, 1'b0));
        q.push_back(mk(1'b0, 32'h13, 2'b00, 1'b0, 32'd0, 1'b1, 32'hFFFF_FF88, 1'b0));
        q.push_back(mk(1'b0, 32'h12, 2'b01, 1'b0, 32'd0, 1'b1, 32'hFFFF_8899, 1'b0));
        q.push_back(mk(1'b0, 32'h10, 2'b01, 1'b1, 32'd0, 1'b1, 32'h0000_AABB, 1'b0));
        q.push_back(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b1, 32'h8899_AABB, 1'b0));
        q.push_back(mk(1'b1, 32'h12, 2'b00, 1'b0, 32'h0000_005C, 1'b1, 32'h885C_AABB, 1'b0));
        q.push_back(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b1, 32'h885C_AABB, 1'b0));
        q.push_back(mk(1'b1, 32'h11, 2'b01, 1'b0, 32'h0000_1234, 1'b0, 32'd0, 1'b0));
        q.push_back(mk(1'b1, 32'h22, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0));
        q.push_back(mk(1'b1, 32'h20, 2'b11, 1'b0, 32'hCAFE_F00D, 1'b0, 32'd0, 1'b0));
        q.push_back(mk(1'b1, 32'h20, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 32'd0, 1'b0));
        q.push_back(mk(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 1'b1, 32'h1234_5678, 1'b0));
        q.push_back(mk(1'b1, 32'h10, 2'b00, 1'b0, 32'h0000_00FF, 1'b0, 32'd0, 1'b1));
        q.push_back(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b1, 32'h885C_AABB, 1'b0));

        hold_rst = 1'b0;
        while (q.size() > 0 || m_busy) begin
            if (!m_busy) begin
                cur = q.pop_front();
                hold_rst = cur.rst_in_write;
                step(cur, 1'b0);
            end else begin
                step(idle_r, hold_rst);
                hold_rst = 1'b0;
            end
        end
        step(idle_r, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            step(rand_req(), $urandom_range(0, 99) < 2);
        end
        step(idle_r, 1'b0);
        step(idle_r, 1'b0);

        for (int i = 0; i < 64; i++) begin
            chk($sformatf("mem_word_%0d", i), dmem[i], ref_word(32'(4 * i)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-wide data memory: async-read/sync-write, byte-addressed, full-word writes only.
- Sits between the core's load/store stage and the data memory.
- Turns byte/half/word loads and stores into word accesses, with sign/zero extension on loads and read-modify-write merging for sub-word stores.
- Flags misaligned or illegal-size requests without touching memory.

Parameters:
ADDR_WIDTH, 32, byte-address width (memory side and core side).
DATA_WIDTH, 32, word width; only 32 is supported (4 byte lanes).

Ports:
i_clock  in  1  clock; all state changes on the rising edge.
i_reset  in  1  synchronous active-high reset.
i_req  in  1  access request from core.
i_we  in  1  1 = store, 0 = load.
i_addr  in  ADDR_WIDTH  byte address.
i_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
i_wdata  in  DATA_WIDTH  store data, right-aligned.
o_ready  out  1  unit can accept a request this cycle.
o_done  out  1  one-cycle pulse: access completed.
o_rdata  out  DATA_WIDTH  extended load data; valid while o_done follows a load, otherwise held.
o_misaligned  out  1  one-cycle pulse: rejected request.
o_mem_addr  out  ADDR_WIDTH  memory address, always word-aligned (bits [1:0] = 0).
o_mem_we  out  1  memory write enable.
o_mem_wdata  out  DATA_WIDTH  memory write data.
i_mem_rdata  in  DATA_WIDTH  async memory read data for o_mem_addr.

Behaviour:
- Reset values: o_ready=1, o_done=0, o_misaligned=0, o_rdata=0, state IDLE.
- While i_reset is high, o_mem_we=0.
- States: IDLE, WRITE.
- Accept condition: i_req & o_ready. o_ready=1 in IDLE, 0 in WRITE.
- Alignment check on accept:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size 11 is always rejected.
  - Rejected: o_misaligned=1 next cycle, o_done=0, o_mem_we=0, no state change.
- In IDLE, o_mem_addr = {i_addr[ADDR_WIDTH-1:2], 2'b00} combinationally.
- In WRITE, o_mem_addr = the same value built from the registered address.
- Load (IDLE):
  - Lane = addr[1:0].
  - Byte: select i_mem_rdata[8*lane +: 8].
  - Half: select [16*addr[1] +: 16].
  - Word: select the whole word.
  - Extend to 32 bits per i_unsigned (ignored for word).
  - Register into o_rdata; o_done=1 next cycle.
  - Load latency 1; back-to-back loads every cycle.
- Word store (IDLE):
  - o_mem_we=1 and o_mem_wdata=i_wdata in the accept cycle.
  - o_done=1 next cycle; stays IDLE.
- Sub-word store, read-modify-write:
  - Accept cycle: register address, size and i_wdata; capture i_mem_rdata as the old word; go to WRITE; o_mem_we=0.
  - Merge: byte replaces lane addr[1:0] with wdata[7:0]; half replaces half addr[1] with wdata[15:0]; all other bits keep the old word.
  - WRITE cycle: o_mem_we=1, o_mem_wdata=merged word; go to IDLE.
  - o_done=1 in the cycle after WRITE, coinciding with o_ready=1.
  - Total occupancy 2 cycles.
- Requests while o_ready=0 are ignored. The core must hold i_req until accepted.
- o_rdata changes only on load completion. Stores and rejects leave it unchanged.
- o_done and o_misaligned are never high together.
- Reset in WRITE: the write is dropped (o_mem_we=0 that cycle); IDLE with o_ready=1 the next cycle; no o_done.
- Addresses at the top of the address space wrap only within the memory. No carry into address bits [1:0].

Test Plan:
1. Preload word 0x10=0x8899AABB. Load byte unsigned 0x11 -> o_done +1 cycle, o_rdata=0x000000AA. Load byte signed 0x13 -> 0xFFFFFF88.
2. Load half signed 0x12 -> 0xFFFF8899. Half unsigned 0x10 -> 0x0000AABB. Word 0x10 -> 0x8899AABB. Issue all three on consecutive cycles with o_ready held at 1.
3. Store byte 0x5C at 0x12 -> o_ready=0 for 1 cycle, o_mem_we=1 with 0x885CAABB at o_mem_addr=0x10, o_done 2 cycles after accept; a subsequent word load returns 0x885CAABB.
4. Store half at 0x11, then word at 0x22, then i_size=11 at 0x20 -> each gives o_misaligned pulse; o_mem_we never asserts; o_done=0; memory unchanged.
5. Store word 0x12345678 at 0x20, then load word 0x20 the next cycle -> single-cycle write, o_rdata=0x12345678.
6. Start store byte 0xFF at 0x10, assert i_reset during WRITE -> no o_mem_we pulse, o_ready=1 after reset, o_done=0, word 0x10 unchanged.
